up_pipe_ctrl: RTL and testbench
===============================

// Module: up_pipe_ctrl
// PURPOSE
//  Pipeline control for the 5-stage accumulator uP (IF/ID/EX/ME/WB), generalised to NUM_ACC accumulators.
//  Owns the PC and per-stage valid/destination tracking. Generates stall, flush and ALU operand-forwarding selects.
//  Sits between DECODEC (ID) and the datapath registers. Adds load-use and flag hazard handling plus bypassing.
// PARAMETERS
//  PC_W     10  PC / instruction-address width
//  BR_W     7   signed relative-branch offset width (BR_W <= PC_W)
//  NUM_ACC  2   number of accumulators (>=2); ACC_W = $clog2(NUM_ACC)
// PORTS
//  clk          in   1      system clock, rising edge
//  Reset        in   1      asynchronous reset, active-high
//  id_jmp       in   1      ID holds an absolute jump
//  id_br_taken  in   1      ID holds a branch whose condition is true
//  id_jmp_dir   in   PC_W   absolute jump target
//  id_br_off    in   BR_W   two's-complement branch offset
//  id_br_acc    in   ACC_W  accumulator whose flags the ID branch tests
//  id_src1_en   in   1      ID instruction reads accumulator id_src1 (ALU in1)
//  id_src1      in   ACC_W  in1 source index
//  id_src2_en   in   1      ID instruction reads accumulator id_src2 (ALU in2)
//  id_src2      in   ACC_W  in2 source index
//  id_dst_en    in   1      ID instruction writes accumulator id_dst
//  id_dst       in   ACC_W  destination index
//  id_is_load   in   1      destination is written from data memory (not ALU)
//  pc           out  PC_W   fetch address to ROM
//  stall        out  1      hold PC and IF/ID; bubble into EX
//  flush        out  1      squash instruction entering ID
//  fwd1_sel     out  2      ALU in1 source: 0 reg, 1 ME alu, 2 WB alu, 3 WB mem
//  fwd2_sel     out  2      ALU in2 source, same encoding
//  ex_valid, me_valid, wb_valid  out 1 each  stage-valid; datapath gates wrEnable / accumulator writes
// BEHAVIOUR
//  Reset (async, active-high): pc=0, all valids=0, stall=0, flush=0, fwdN_sel=0, tracked dst/flags cleared.
//  id_valid is internal; it resets to 0 and becomes 1 one cycle after reset release (ROM read latency 1).
//  Next PC priority: stall (hold) > id_jmp (id_jmp_dir) > id_br_taken (sext(id_br_off)+pc_id) > pc+1.
//   pc_id = registered PC of the ID instruction. Addition wraps modulo 2^PC_W.
//   Jump/branch inputs are ignored when !id_valid or stall=1.
//  flush = id_valid & !stall & (id_jmp | id_br_taken). Next cycle id_valid=0 (one-slot squash). No stall after.
//  Per stage EX/ME/WB registers {valid, dst_en, dst, is_load} advance every cycle (no stall beyond ID).
//  Load-use stall: ex_valid & ex_dst_en & ex_is_load & an enabled ID src equals ex_dst.
//  Flag stall: id_valid & (id_jmp|id_br_taken... evaluated on id_br_acc) & any valid EX/ME/WB writes id_br_acc.
//   Decoder is told stall via the stall port; branch re-evaluates each cycle until clear.
//  stall=1: pc and ID content hold; EX receives valid=0 (bubble). Stall and flush are never both 1.
//  Forwarding (per operand, computed in EX from registered src): ME match with !me_is_load -> 1.
//   Else WB match -> 2 if !wb_is_load, 3 if wb_is_load. Else 0. Nearest (ME) wins when both match.
//   Match = stage valid & dst_en & dst==src & src_en. Invalid stage never forwards.
//  Reset mid-stream: all in-flight instructions dropped; fetch restarts at 0.
// STRUCTURE
//  up_pkg: FWD_REG/FWD_ME_ALU/FWD_WB_ALU/FWD_WB_MEM localparams, stage-tracking struct widths.
//  Sub-module up_fwd_sel (comparator chain for one operand), instantiated twice.
// TESTING
//  Reset released, no branches -> pc 0,1,2,3...; id_valid rises 1 cycle after release; wrap 1023->0.
//  A<=A+1 then B<=A+B back-to-back -> fwd1_sel=1 in 2nd op's EX; with one NOP between -> fwd1_sel=2.
//  Load A from mem, next instr reads A -> stall=1 one cycle, EX bubble; then fwd1_sel=3.
//  Branch at pc_id=5, off=7'h7E (-2) -> flush=1, next pc=3; instr fetched at 6 never valid in EX.
//  Branch tests A while ALU op writing A in EX -> stall 3 cycles, then resolves with correct target.
//  Reset asserted while stalled with load in ME -> all valids 0 immediately, pc=0, stall=0.

Source files
------------

// File: rtl/up_pipe_ctrl_pkg.sv
// Shared definitions for the accumulator uP pipeline controller:
// forwarding-select encoding and a helper for the accumulator index width.
package up_pipe_ctrl_pkg;

   typedef logic [1:0] fwd_sel_t;

   // ALU operand source selects driven towards the EX-stage operand muxes
   localparam fwd_sel_t FWD_REG    = 2'd0;  // register-file value read in ID
   localparam fwd_sel_t FWD_ME_ALU = 2'd1;  // ALU result sitting in ME
   localparam fwd_sel_t FWD_WB_ALU = 2'd2;  // ALU result sitting in WB
   localparam fwd_sel_t FWD_WB_MEM = 2'd3;  // load data sitting in WB

   // Per-stage tracking record is {valid, dst_en, dst[ACC_W], is_load}
   localparam int STAGE_FLAG_BITS = 3;

   // Accumulator index width; at least one bit even for tiny configurations
   function automatic int acc_width(input int num_acc);
      return (num_acc <= 2) ? 1 : $clog2(num_acc);
   endfunction

endpackage

// File: rtl/up_pipe_ctrl_if.sv
// Decoder <-> pipeline-controller bundle. The decoder side (master) presents
// the ID-stage instruction fields; the controller side (slave) returns the
// fetch address, hazard controls, forwarding selects and stage valids.
interface up_pipe_ctrl_if
   import up_pipe_ctrl_pkg::*;
#(
   parameter int PC_W    = 10,
   parameter int BR_W    = 7,
   parameter int NUM_ACC = 2
);
   localparam int ACC_W = acc_width(NUM_ACC);

   // ID-stage instruction fields
   logic             id_jmp;
   logic             id_br_taken;
   logic [PC_W-1:0]  id_jmp_dir;
   logic [BR_W-1:0]  id_br_off;
   logic [ACC_W-1:0] id_br_acc;
   logic             id_src1_en;
   logic [ACC_W-1:0] id_src1;
   logic             id_src2_en;
   logic [ACC_W-1:0] id_src2;
   logic             id_dst_en;
   logic [ACC_W-1:0] id_dst;
   logic             id_is_load;

   // Controller results
   logic [PC_W-1:0]  pc;
   logic             stall;
   logic             flush;
   fwd_sel_t         fwd1_sel;
   fwd_sel_t         fwd2_sel;
   logic             ex_valid;
   logic             me_valid;
   logic             wb_valid;

   modport master (
      output id_jmp, id_br_taken, id_jmp_dir, id_br_off, id_br_acc,
             id_src1_en, id_src1, id_src2_en, id_src2,
             id_dst_en, id_dst, id_is_load,
      input  pc, stall, flush, fwd1_sel, fwd2_sel,
             ex_valid, me_valid, wb_valid
   );

   modport slave (
      input  id_jmp, id_br_taken, id_jmp_dir, id_br_off, id_br_acc,
             id_src1_en, id_src1, id_src2_en, id_src2,
             id_dst_en, id_dst, id_is_load,
      output pc, stall, flush, fwd1_sel, fwd2_sel,
             ex_valid, me_valid, wb_valid
   );

endinterface

// File: rtl/up_pipe_ctrl_fwd_sel.sv
// Forwarding select for one ALU operand in EX. The nearest producer wins:
// an ALU result in ME first, then anything in WB (ALU result or load data).
// A load still in ME has no data yet, so it falls through to the WB check.
module up_fwd_sel
   import up_pipe_ctrl_pkg::*;
#(
   parameter int ACC_W = 1
) (
   input  logic             src_en,
   input  logic [ACC_W-1:0] src,
   input  logic             me_valid,
   input  logic             me_dst_en,
   input  logic [ACC_W-1:0] me_dst,
   input  logic             me_is_load,
   input  logic             wb_valid,
   input  logic             wb_dst_en,
   input  logic [ACC_W-1:0] wb_dst,
   input  logic             wb_is_load,
   output fwd_sel_t         sel
);

   logic me_hit;
   logic wb_hit;

   // Compare the operand against the ME and WB destinations, ME taking priority
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      sel    = FWD_REG;
      me_hit = src_en & me_valid & me_dst_en & (me_dst == src);
      wb_hit = src_en & wb_valid & wb_dst_en & (wb_dst == src);
      if (me_hit && !me_is_load) begin
         sel = FWD_ME_ALU;
      end else if (wb_hit) begin
         sel = wb_is_load ? FWD_WB_MEM : FWD_WB_ALU;
      end
   end

endmodule

// File: rtl/up_pipe_ctrl.sv
// Pipeline control for the 5-stage accumulator uP (IF/ID/EX/ME/WB).
// Owns the PC, tracks valid/destination per stage, and generates stall,
// flush and ALU operand-forwarding selects.
module up_pipe_ctrl
   import up_pipe_ctrl_pkg::*;
#(
   parameter int PC_W    = 10,
   parameter int BR_W    = 7,
   parameter int NUM_ACC = 2
) (
   input  logic         clk,
   input  logic         Reset,
   up_pipe_ctrl_if.slave bus
);

   localparam int ACC_W = acc_width(NUM_ACC);

   typedef logic [ACC_W-1:0] acc_t;

   typedef struct packed {
      logic valid;
      logic dst_en;
      acc_t dst;
      logic is_load;
   } stage_t;

   localparam stage_t STAGE_EMPTY = '0;

   // Fetch / ID state
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_id_q;
   logic            id_valid_q;

   // Downstream stage tracking plus EX operand sources for forwarding
   stage_t ex_q, me_q, wb_q;
   logic   ex_src1_en_q, ex_src2_en_q;
   acc_t   ex_src1_q, ex_src2_q;

   // Hazard / control signals
   logic            load_use;
   logic            flag_hazard;
   logic            stall;
   logic            redirect;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] pc_next;

   function automatic logic writes_acc(input stage_t s, input acc_t a);
      return s.valid & s.dst_en & (s.dst == a);
   endfunction

   // Hazard detection and next-PC selection
   always_comb begin
      load_use = ex_q.valid & ex_q.dst_en & ex_q.is_load &
                 ((bus.id_src1_en & (bus.id_src1 == ex_q.dst)) |
                  (bus.id_src2_en & (bus.id_src2 == ex_q.dst)));
      // Any control transfer waits until no in-flight instruction can still
      // change the flags of the accumulator it examines.
      flag_hazard = id_valid_q & (bus.id_jmp | bus.id_br_taken) &
                    (writes_acc(ex_q, bus.id_br_acc) |
                     writes_acc(me_q, bus.id_br_acc) |
                     writes_acc(wb_q, bus.id_br_acc));
      stall     = load_use | flag_hazard;
      redirect  = id_valid_q & ~stall & (bus.id_jmp | bus.id_br_taken);
      br_target = pc_id_q + PC_W'($signed(bus.id_br_off));
      pc_next   = pc_q + 1'b1;
      if (stall) begin
         pc_next = pc_q;
      end else if (id_valid_q && bus.id_jmp) begin
         pc_next = bus.id_jmp_dir;
      end else if (id_valid_q && bus.id_br_taken) begin
         pc_next = br_target;
      end
   end

   // PC and ID slot: hold on stall, squash the fetched slot on redirect
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         pc_q       <= '0;
         pc_id_q    <= '0;
         id_valid_q <= 1'b0;
      end else if (!stall) begin
         pc_q       <= pc_next;
         pc_id_q    <= pc_q;
         id_valid_q <= ~redirect;
      end
   end

   // EX/ME/WB tracking advances every cycle; a stall injects a bubble into EX
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         ex_q         <= STAGE_EMPTY;
         me_q         <= STAGE_EMPTY;
         wb_q         <= STAGE_EMPTY;
         ex_src1_en_q <= 1'b0;
         ex_src2_en_q <= 1'b0;
         ex_src1_q    <= '0;
         ex_src2_q    <= '0;
      end else begin
         ex_q.valid   <= id_valid_q & ~stall;
         ex_q.dst_en  <= id_valid_q & ~stall & bus.id_dst_en;
         ex_q.dst     <= bus.id_dst;
         ex_q.is_load <= bus.id_is_load;
         me_q         <= ex_q;
         wb_q         <= me_q;
         ex_src1_en_q <= id_valid_q & ~stall & bus.id_src1_en;
         ex_src2_en_q <= id_valid_q & ~stall & bus.id_src2_en;
         ex_src1_q    <= bus.id_src1;
         ex_src2_q    <= bus.id_src2;
      end
   end

   up_fwd_sel #(.ACC_W(ACC_W)) u_fwd1 (
      .src_en     (ex_src1_en_q),
      .src        (ex_src1_q),
      .me_valid   (me_q.valid),
      .me_dst_en  (me_q.dst_en),
      .me_dst     (me_q.dst),
      .me_is_load (me_q.is_load),
      .wb_valid   (wb_q.valid),
      .wb_dst_en  (wb_q.dst_en),
      .wb_dst     (wb_q.dst),
      .wb_is_load (wb_q.is_load),
      .sel        (bus.fwd1_sel)
   );

   up_fwd_sel #(.ACC_W(ACC_W)) u_fwd2 (
      .src_en     (ex_src2_en_q),
      .src        (ex_src2_q),
      .me_valid   (me_q.valid),
      .me_dst_en  (me_q.dst_en),
      .me_dst     (me_q.dst),
      .me_is_load (me_q.is_load),
      .wb_valid   (wb_q.valid),
      .wb_dst_en  (wb_q.dst_en),
      .wb_dst     (wb_q.dst),
      .wb_is_load (wb_q.is_load),
      .sel        (bus.fwd2_sel)
   );

   assign bus.pc       = pc_q;
   assign bus.stall    = stall;
   assign bus.flush    = redirect;
   assign bus.ex_valid = ex_q.valid;
   assign bus.me_valid = me_q.valid;
   assign bus.wb_valid = wb_q.valid;

endmodule

// File: tb/tb_up_pipe_ctrl.sv
// Self-checking bench for up_pipe_ctrl: directed scenarios followed by
// random decoder traffic, all compared against an instruction-level model.
module tb_up_pipe_ctrl;

   localparam int PC_W    = 10;
   localparam int BR_W    = 7;
   localparam int NUM_ACC = 2;
   localparam int PC_MASK = (1 << PC_W) - 1;

   logic clk = 1'b0;
   logic Reset;

   always #5 clk = ~clk;

   up_pipe_ctrl_if #(.PC_W(PC_W), .BR_W(BR_W), .NUM_ACC(NUM_ACC)) bus ();

   up_pipe_ctrl #(.PC_W(PC_W), .BR_W(BR_W), .NUM_ACC(NUM_ACC)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   // Decoder view of the instruction currently sitting in ID
   typedef struct {
      bit jmp; bit br; int dir; int off; int bacc;
      bit s1_en; int s1; bit s2_en; int s2; bit d_en; int d; bit ld;
   } in_t;

   // An instruction in flight past ID
   typedef struct {
      bit valid; bit dst_en; int dst; bit is_load;
      bit s1_en; int s1; bit s2_en; int s2;
   } instr_t;

   instr_t pipe [3];   // 0 = EX, 1 = ME, 2 = WB
   int     m_pc, m_pc_id;
   bit     m_id_valid, m_last_stall;
   int     checks, errors;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic in_t nop();
      in_t i = '{default: 0};
      return i;
   endfunction

   function automatic in_t alu(int d, bit s1e, int s1, bit s2e, int s2, bit ld);
      in_t i = '{default: 0};
      i.d_en = 1; i.d = d; i.s1_en = s1e; i.s1 = s1; i.s2_en = s2e; i.s2 = s2; i.ld = ld;
      return i;
   endfunction

   task automatic apply(input in_t i);
      bus.id_jmp      = i.jmp;
      bus.id_br_taken = i.br;
      bus.id_jmp_dir  = i.dir[PC_W-1:0];
      bus.id_br_off   = i.off[BR_W-1:0];
      bus.id_br_acc   = i.bacc[0:0];
      bus.id_src1_en  = i.s1_en;
      bus.id_src1     = i.s1[0:0];
      bus.id_src2_en  = i.s2_en;
      bus.id_src2     = i.s2[0:0];
      bus.id_dst_en   = i.d_en;
      bus.id_dst      = i.d[0:0];
      bus.id_is_load  = i.ld;
   endtask

   // ---------------- reference model ----------------
   task automatic m_reset();
      m_pc = 0; m_pc_id = 0; m_id_valid = 0; m_last_stall = 0;
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
   endtask

   function automatic bit m_writes(instr_t r, int a);
      return r.valid && r.dst_en && (r.dst == a);
   endfunction

   function automatic bit m_stall();
      bit lu = 0;
      bit hz = 0;
      if (pipe[0].valid && pipe[0].dst_en && pipe[0].is_load)
         lu = (bus.id_src1_en && int'(bus.id_src1) == pipe[0].dst) ||
              (bus.id_src2_en && int'(bus.id_src2) == pipe[0].dst);
      for (int k = 0; k < 3; k++)
         if (m_writes(pipe[k], int'(bus.id_br_acc))) hz = 1;
      hz = hz && m_id_valid && (bus.id_jmp || bus.id_br_taken);
      return lu || hz;
   endfunction

   function automatic int m_fwd(bit en, int src);
      if (!pipe[0].valid || !en) return 0;
      if (m_writes(pipe[1], src) && !pipe[1].is_load) return 1;
      if (m_writes(pipe[2], src)) return pipe[2].is_load ? 3 : 2;
      return 0;
   endfunction

   task automatic check_all(input string tag);
      bit st = m_stall();
      chk({tag, "/pc"},       bus.pc,       m_pc);
      chk({tag, "/stall"},    bus.stall,    st);
      chk({tag, "/flush"},    bus.flush,    m_id_valid && !st && (bus.id_jmp || bus.id_br_taken));
      chk({tag, "/fwd1"},     bus.fwd1_sel, m_fwd(pipe[0].s1_en, pipe[0].s1));
      chk({tag, "/fwd2"},     bus.fwd2_sel, m_fwd(pipe[0].s2_en, pipe[0].s2));
      chk({tag, "/ex_valid"}, bus.ex_valid, pipe[0].valid);
      chk({tag, "/me_valid"}, bus.me_valid, pipe[1].valid);
      chk({tag, "/wb_valid"}, bus.wb_valid, pipe[2].valid);
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_update();
      instr_t n = '{default: 0};
      bit st = m_stall();
      bit fl = m_id_valid && !st && (bus.id_jmp || bus.id_br_taken);
      int nxt, o;
      if (m_id_valid && !st) begin
         n.valid = 1; n.dst_en = bus.id_dst_en; n.dst = int'(bus.id_dst); n.is_load = bus.id_is_load;
         n.s1_en = bus.id_src1_en; n.s1 = int'(bus.id_src1);
         n.s2_en = bus.id_src2_en; n.s2 = int'(bus.id_src2);
      end
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = n;
      if (!st) begin
         if (m_id_valid && bus.id_jmp) nxt = int'(bus.id_jmp_dir);
         else if (m_id_valid && bus.id_br_taken) begin
            o = int'(bus.id_br_off);
            if (o >= (1 << (BR_W - 1))) o -= (1 << BR_W);
            nxt = (m_pc_id + o) & PC_MASK;
         end else nxt = (m_pc + 1) & PC_MASK;
         m_pc_id = m_pc; m_id_valid = !fl; m_pc = nxt;
      end
      m_last_stall = st;
   endtask

   task automatic step_noedge(input in_t i, input string tag);
      apply(i);
      #2;
      check_all(tag);
      model_update();
   endtask

   task automatic step(input in_t i, input string tag);
      @(posedge clk);
      #1;
      step_noedge(i, tag);
   endtask

   task automatic drain();
      for (int k = 0; k < 3; k++) step(nop(), "drain");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      in_t br, r;
      int  tgt;
      int  wrap_pc [5] = '{1020, 1021, 1022, 1023, 0};

      checks = 0; errors = 0;
      Reset = 1'b1;
      apply(nop());
      m_reset();
      #3;
      check_all("reset");
      chk("rst_pc", bus.pc, 0);
      chk("rst_stall", bus.stall, 0);

      // Release reset: sequential fetch, ID valid one cycle later
      @(posedge clk); #1 Reset = 1'b0;
      step_noedge(nop(), "boot0");
      for (int k = 1; k <= 4; k++) begin
         step(nop(), "boot");
         chk("boot_pc", bus.pc, k);
         if (k == 1) chk("boot_ex_invalid", bus.ex_valid, 0);
         if (k == 2) chk("boot_ex_valid", bus.ex_valid, 1);
      end

      // Backward branch at pc_id=5 with offset -2
      for (int k = 0; k < 20 && !(m_id_valid && m_pc_id == 5); k++) step(nop(), "to5");
      br = nop(); br.br = 1; br.off = 'h7E; br.bacc = 0;
      step(br, "br5");
      chk("br5_flush", bus.flush, 1);
      chk("br5_fetch6", bus.pc, 6);
      step(nop(), "br5_next");
      chk("br5_target", bus.pc, 3);
      step(nop(), "br5_squash");
      chk("br5_squashed_ex", bus.ex_valid, 0);

      // Back-to-back dependency forwards from ME, one NOP apart from WB
      drain();
      step(alu(0, 1, 0, 0, 0, 0), "ab_i1");
      step(alu(1, 1, 0, 1, 1, 0), "ab_i2");
      step(nop(), "ab_ex");
      chk("fwd_me_alu", bus.fwd1_sel, 1);
      drain();
      step(alu(0, 1, 0, 0, 0, 0), "anb_i1");
      step(nop(), "anb_nop");
      step(alu(1, 1, 0, 1, 1, 0), "anb_i2");
      step(nop(), "anb_ex");
      chk("fwd_wb_alu", bus.fwd1_sel, 2);

      // Load-use: one stall cycle with a bubble, then forward load data
      drain();
      step(alu(0, 0, 0, 0, 0, 1), "lu_load");
      step(alu(1, 1, 0, 0, 0, 0), "lu_use");
      chk("lu_stall", bus.stall, 1);
      step(alu(1, 1, 0, 0, 0, 0), "lu_hold");
      chk("lu_stall_clear", bus.stall, 0);
      chk("lu_bubble", bus.ex_valid, 0);
      step(nop(), "lu_ex");
      chk("fwd_wb_mem", bus.fwd1_sel, 3);

      // Branch on flags of an accumulator still being written
      drain();
      step(alu(0, 1, 0, 0, 0, 0), "fl_alu");
      br = nop(); br.br = 1; br.off = 4; br.bacc = 0;
      tgt = (m_pc_id + 4) & PC_MASK;
      for (int k = 0; k < 3; k++) begin
         step(br, "fl_wait");
         chk("fl_stall", bus.stall, 1);
      end
      step(br, "fl_go");
      chk("fl_go_stall", bus.stall, 0);
      chk("fl_go_flush", bus.flush, 1);
      step(nop(), "fl_target");
      chk("fl_target_pc", bus.pc, tgt);

      // PC wrap 1023 -> 0
      drain();
      br = nop(); br.jmp = 1; br.dir = 1020;
      step(br, "jmp");
      for (int k = 0; k < 5; k++) begin
         step(nop(), "wrap");
         chk("wrap_pc", bus.pc, wrap_pc[k]);
      end

      // Reset while stalled with a load in ME
      drain();
      step(alu(0, 0, 0, 0, 0, 1), "rm_ld0");
      step(alu(1, 0, 0, 0, 0, 1), "rm_ld1");
      step(alu(0, 1, 1, 0, 0, 0), "rm_use");
      chk("rm_stalled", bus.stall, 1);
      chk("rm_load_in_me", bus.me_valid, 1);
      #1 Reset = 1'b1;
      #1;
      m_reset();
      check_all("rst_mid");
      chk("rm_pc", bus.pc, 0);
      chk("rm_stall", bus.stall, 0);
      chk("rm_ex", bus.ex_valid, 0);
      chk("rm_me", bus.me_valid, 0);
      chk("rm_wb", bus.wb_valid, 0);
      @(posedge clk); #1 Reset = 1'b0;
      step_noedge(nop(), "rm_boot");

      // Random decoder traffic; a stalled instruction is held by the decoder
      r = nop();
      for (int n = 0; n < 600; n++) begin
         if (!m_last_stall) begin
            r.jmp   = ($urandom_range(0, 19) == 0);
            r.br    = !r.jmp && ($urandom_range(0, 7) == 0);
            r.dir   = int'($urandom_range(0, PC_MASK));
            r.off   = int'($urandom_range(0, (1 << BR_W) - 1));
            r.bacc  = int'($urandom_range(0, NUM_ACC - 1));
            r.s1_en = $urandom_range(0, 1) == 1;
            r.s1    = int'($urandom_range(0, NUM_ACC - 1));
            r.s2_en = $urandom_range(0, 1) == 1;
            r.s2    = int'($urandom_range(0, NUM_ACC - 1));
            r.d_en  = $urandom_range(0, 3) != 0;
            r.d     = int'($urandom_range(0, NUM_ACC - 1));
            r.ld    = ($urandom_range(0, 2) == 0);
         end
         step(r, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
